// File: rtl/smc777_pkg.sv
// smc777_pkg: shared dpram geometry, ioctl constants and upload FSM states
package smc777_pkg;

    localparam int         RAM_ADDR_W   = 14;
    localparam logic [7:0] UPLOAD_INDEX = 8'h01;
    localparam logic [7:0] FILL_BYTE    = 8'hFF;

    typedef enum logic [2:0] {IDLE, ARMED, FETCH, WAIT_Q, PRESENT} state_t;

endpackage

// File: rtl/smc777_ram_upload.sv
// smc777_ram_upload: serves HPS upload reads from dpram port B with a wait
// handshake, keeping a per-session byte count and mod-256 checksum
module smc777_ram_upload
    import smc777_pkg::*;
#(
    parameter int         ADDR_W       = RAM_ADDR_W,
    parameter int         RAM_LATENCY  = 1,
    parameter logic [7:0] UPLOAD_INDEX = smc777_pkg::UPLOAD_INDEX,
    parameter logic [7:0] FILL_BYTE    = smc777_pkg::FILL_BYTE
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ioctl_upload,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_rd,
    input  logic [24:0]       ioctl_addr,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd,
    input  logic [7:0]        ram_q,
    output logic [15:0]       byte_count,
    output logic [7:0]        checksum,
    output logic              overrun,
    output logic              done
);

    state_t     state, state_n;
    logic [1:0] cnt;
    logic       oow;
    logic       active, in_win, accept;
    logic [7:0] serve_byte;

    assign active     = ioctl_upload && (ioctl_index == UPLOAD_INDEX);
    assign in_win     = (ioctl_addr >> ADDR_W) == 25'd0;
    assign accept     = (state == ARMED) && active && ioctl_rd;
    assign serve_byte = oow ? FILL_BYTE : ram_q;

    // PRESENT is entered in the cycle ram_q is valid, so the counter holds
    // the number of extra WAIT_Q cycles beyond the first read cycle
    always_comb begin
        state_n    = state;
        ram_rd     = state == FETCH;
        ioctl_wait = state == FETCH || state == WAIT_Q || state == PRESENT;
        case (state)
            IDLE:    state_n = active ? ARMED : IDLE;
            ARMED:   state_n = ioctl_rd ? (in_win ? FETCH : PRESENT) : ARMED;
            FETCH:   state_n = (RAM_LATENCY <= 1) ? PRESENT : WAIT_Q;
            WAIT_Q:  state_n = (cnt <= 2'd1) ? PRESENT : WAIT_Q;
            PRESENT: state_n = ARMED;
            default: state_n = IDLE;
        endcase
        if (state != IDLE && !active)
            state_n = IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            oow        <= 1'b0;
            ram_addr   <= '0;
            ioctl_din  <= '0;
            byte_count <= '0;
            checksum   <= '0;
            overrun    <= 1'b0;
            done       <= 1'b0;
        end else begin
            state <= state_n;
            done  <= (state != IDLE) && !active;
            if (state == IDLE && active) begin
                byte_count <= '0;
                checksum   <= '0;
                overrun    <= 1'b0;
            end
            if (active && ioctl_rd && ioctl_wait)
                overrun <= 1'b1;
            if (accept) begin
                oow <= !in_win;
                if (in_win)
                    ram_addr <= ioctl_addr[ADDR_W-1:0];
            end
            if (state == FETCH)
                cnt <= 2'(RAM_LATENCY - 1);
            if (state == WAIT_Q)
                cnt <= cnt - 2'd1;
            if (state == PRESENT && active) begin
                ioctl_din  <= serve_byte;
                byte_count <= byte_count + 16'd1;
                checksum   <= checksum + serve_byte;
            end
        end
    end

endmodule

// File: tb/tb_smc777_ram_upload.sv
// tb_smc777_ram_upload: table-driven scoreboard bench for the upload reader,
// one instance at RAM latency 1 and one at latency 3
module tb_smc777_ram_upload;

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  exp_din;
        int          lat;
        int          rds;
    } vec_t;

    logic        clk = 1'b0;
    int          checks = 0, errors = 0;
    logic [7:0]  mem [0:16383];
    logic [7:0]  sb_q [$];
    int          rdc1 = 0, rdc3 = 0;

    logic        rst1_n, up1, rd1;
    logic [7:0]  idx1, din1, q1, sum1;
    logic [24:0] addr1;
    logic        wait1, ram_rd1, ovr1, done1;
    logic [13:0] ram_addr1;
    logic [15:0] cnt1;

    logic        rst3_n, up3, rd3;
    logic [7:0]  idx3, din3, sum3;
    logic [24:0] addr3;
    logic        wait3, ram_rd3, ovr3, done3;
    logic [13:0] ram_addr3;
    logic [15:0] cnt3;
    logic [7:0]  p3 [0:2];

    always #5 clk = ~clk;

    smc777_ram_upload #(.RAM_LATENCY(1)) dut1 (
        .clk(clk), .reset_n(rst1_n), .ioctl_upload(up1), .ioctl_index(idx1),
        .ioctl_rd(rd1), .ioctl_addr(addr1), .ioctl_din(din1), .ioctl_wait(wait1),
        .ram_addr(ram_addr1), .ram_rd(ram_rd1), .ram_q(q1), .byte_count(cnt1),
        .checksum(sum1), .overrun(ovr1), .done(done1)
    );

    smc777_ram_upload #(.RAM_LATENCY(3)) dut3 (
        .clk(clk), .reset_n(rst3_n), .ioctl_upload(up3), .ioctl_index(idx3),
        .ioctl_rd(rd3), .ioctl_addr(addr3), .ioctl_din(din3), .ioctl_wait(wait3),
        .ram_addr(ram_addr3), .ram_rd(ram_rd3), .ram_q(p3[2]), .byte_count(cnt3),
        .checksum(sum3), .overrun(ovr3), .done(done3)
    );

    // Dpram models: latency 1 only updates on a read strobe, latency 3 is a free-running pipe
    always @(posedge clk) begin
        if (ram_rd1) q1 <= mem[ram_addr1];
        p3[0] <= mem[ram_addr3];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
        if (ram_rd1) rdc1++;
        if (ram_rd3) rdc3++;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic do_rd(input logic [24:0] a, input logic [7:0] exp, input int lat, input int rds);
        int n, r0;
        logic [7:0] e;
        r0 = rdc1;
        @(negedge clk);
        rd1 = 1'b1;
        addr1 = a;
        sb_q.push_back(exp);
        @(negedge clk);
        rd1 = 1'b0;
        n = 1;
        while (wait1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, lat);
        check("ram_rd count", rdc1 - r0, rds);
        if (sb_q.size() == 0) check("scoreboard empty", 0, 1);
        else begin
            e = sb_q.pop_front();
            check("ioctl_din", din1, e);
        end
    endtask

    initial begin
        vec_t vecs [7];
        logic [7:0]  es;
        logic [15:0] ec;
        logic [7:0]  hold;
        int          n, r0;
        for (int i = 0; i < 16384; i++) mem[i] = 8'(i) ^ 8'h3C;
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
        mem[16383] = 8'h5A;
        vecs[0] = '{25'h0000000, 8'h11, 3, 1};
        vecs[1] = '{25'h0000001, 8'h22, 3, 1};
        vecs[2] = '{25'h0000002, 8'h33, 3, 1};
        vecs[3] = '{25'h0000003, 8'h44, 3, 1};
        vecs[4] = '{25'h0004000, 8'hFF, 2, 0};
        vecs[5] = '{25'h1FFFFFF, 8'hFF, 2, 0};
        vecs[6] = '{25'h0000100, 8'h3C, 3, 1};
        rst1_n = 1'b0; up1 = 1'b0; idx1 = 8'h01; rd1 = 1'b0; addr1 = '0;
        rst3_n = 1'b0; up3 = 1'b0; idx3 = 8'h01; rd3 = 1'b0; addr3 = '0;
        repeat (2) @(negedge clk);
        check("reset din", din1, 0);
        check("reset wait", wait1, 0);
        check("reset ram_rd", ram_rd1, 0);
        check("reset ram_addr", ram_addr1, 0);
        check("reset count", cnt1, 0);
        check("reset sum", sum1, 0);
        check("reset overrun", ovr1, 0);
        check("reset done", done1, 0);
        rst1_n = 1'b1;
        rst3_n = 1'b1;
        up1 = 1'b1;
        repeat (2) @(negedge clk);

        ec = 0;
        es = 0;
        for (int i = 0; i < 7; i++) begin
            do_rd(vecs[i].addr, vecs[i].exp_din, vecs[i].lat, vecs[i].rds);
            ec++;
            es += vecs[i].exp_din;
            check("byte_count", cnt1, ec);
            check("checksum", sum1, es);
        end
        check("checksum after 0..3 then fills", {24'd0, 8'hAA} + 8'hFF + 8'hFF, 32'h2A8);

        hold = din1;
        repeat (3) @(negedge clk);
        check("din hold", din1, hold);
        check("overrun clean", ovr1, 0);

        // back-to-back rd: second one lands in FETCH and must be dropped
        r0 = rdc1;
        @(negedge clk); rd1 = 1'b1; addr1 = 25'd1; sb_q.push_back(8'h22);
        @(negedge clk); addr1 = 25'd2;
        check("busy wait", wait1, 1);
        @(negedge clk); rd1 = 1'b0;
        n = 2;
        while (wait1 && n < 30) begin @(negedge clk); n++; end
        check("overrun latency", n, 3);
        check("overrun din", din1, sb_q.pop_front());
        check("overrun flag", ovr1, 1);
        repeat (3) @(negedge clk);
        check("overrun one ram_rd", rdc1 - r0, 1);
        check("overrun count", cnt1, ec + 16'd1);
        check("overrun no second", wait1, 0);

        @(negedge clk); up1 = 1'b0;
        @(negedge clk);
        check("armed drop done", done1, 1);
        @(negedge clk);
        check("done one cycle", done1, 0);
        check("overrun sticky", ovr1, 1);

        idx1 = 8'h02; up1 = 1'b1;
        hold = din1;
        r0 = rdc1;
        @(negedge clk); rd1 = 1'b1; addr1 = 25'd0;
        @(negedge clk); rd1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("wrong index wait", wait1, 0);
            @(negedge clk);
        end
        check("wrong index din", din1, hold);
        check("wrong index ram_rd", rdc1 - r0, 0);

        idx1 = 8'h01;
        repeat (2) @(negedge clk);
        check("restart overrun", ovr1, 0);
        check("restart count", cnt1, 0);
        check("restart sum", sum1, 0);
        do_rd(25'd3, 8'h44, 3, 1);
        check("restart count 1", cnt1, 1);
        check("restart sum 1", sum1, 8'h44);

        @(negedge clk); rd1 = 1'b1; addr1 = 25'd2;
        @(negedge clk); rd1 = 1'b0;
        @(negedge clk); up1 = 1'b0;
        @(negedge clk);
        check("abort wait", wait1, 0);
        check("abort done", done1, 1);
        check("abort count", cnt1, 1);
        check("abort sum", sum1, 8'h44);
        check("abort din", din1, 8'h44);
        @(negedge clk);
        check("abort done pulse", done1, 0);

        up3 = 1'b1;
        repeat (2) @(negedge clk);
        r0 = rdc3;
        @(negedge clk); rd3 = 1'b1; addr3 = 25'h3FFF;
        @(negedge clk); rd3 = 1'b0;
        check("lat3 ram_rd", ram_rd3, 1);
        check("lat3 ram_addr", ram_addr3, 14'h3FFF);
        n = 1;
        while (wait3 && n < 30) begin @(negedge clk); n++; end
        check("lat3 latency", n, 5);
        check("lat3 din", din3, 8'h5A);
        check("lat3 count", cnt3, 1);
        check("lat3 ram_rd count", rdc3 - r0, 1);

        @(negedge clk); rd3 = 1'b1; addr3 = 25'd0;
        @(negedge clk); rd3 = 1'b0;
        @(negedge clk);
        check("lat3 mid wait", wait3, 1);
        #2 rst3_n = 1'b0;
        #1;
        check("async din", din3, 0);
        check("async wait", wait3, 0);
        check("async count", cnt3, 0);
        check("async sum", sum3, 0);
        check("async ram_addr", ram_addr3, 0);
        check("async ram_rd", ram_rd3, 0);
        check("async done", done3, 0);
        @(negedge clk);
        check("reset no done", done3, 0);
        rst3_n = 1'b1;

        check("scoreboard drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
